// File: rtl/aoi_sweep_checker.sv
// ---------------------------------------------------------------------------
// aoi_sweep_checker
// Self-test driver and checker for a 2+2-input AND-OR-invert gate
// (o = ~((a1&a0) | (b1&b0))). On start it steps {a,b} through all 16
// combinations PASSES times. It holds each vector SETTLE+1 cycles and
// samples the gate output on the last cycle of each vector. It counts
// mismatches against the expected AOI value and records the first
// failing vector.
//
// Parameters:
//   SETTLE  extra hold cycles per vector before sampling (0 allowed)
//   PASSES  full 16-vector sweeps per run (>=1)
//   ERR_W   width of the saturating error counter
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          run request (level-sampled in IDLE)
//   abort          cancel the current run (RUN only)
//   a_out, b_out   registered drive of gate inputs a[1:0], b[1:0]
//   o_in           gate output o
//   busy           run in progress
//   done           one-cycle pulse at run completion
//   pass           last completed run had zero mismatches
//   err_count      mismatches in last/current run, saturating
//   err_valid      at least one mismatch recorded this run
//   first_err_vec  {a,b} of the first mismatch this run
// ---------------------------------------------------------------------------
module aoi_sweep_checker #(
   parameter int SETTLE = 1,
   parameter int PASSES = 1,
   parameter int ERR_W  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic [1:0]       a_out,
   output logic [1:0]       b_out,
   input  logic             o_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             err_valid,
   output logic [3:0]       first_err_vec
);

   localparam int HOLD_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   localparam int PC_W   = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(SETTLE);
   localparam logic [PC_W-1:0]   PASS_LAST = PC_W'(PASSES - 1);
   localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [3:0]        r_vec;
   logic [HOLD_W-1:0] r_hold;
   logic [PC_W-1:0]   r_pass_cnt;
   logic [ERR_W-1:0]  r_err_count;
   logic              r_err_valid;
   logic [3:0]        r_first_err;
   logic              r_pass;

   logic w_accept;
   logic w_sample;
   logic w_last;
   logic w_exp;
   logic w_mismatch;

   assign w_accept   = (r_state == S_IDLE) && start;
   // abort wins over a sample on the same edge: that sample is discarded
   assign w_sample   = (r_state == S_RUN) && (r_hold == HOLD_MAX) && !abort;
   assign w_last     = w_sample && (r_vec == 4'hF) && (r_pass_cnt == PASS_LAST);
   assign w_exp      = ~((r_vec[3] & r_vec[2]) | (r_vec[1] & r_vec[0]));
   assign w_mismatch = w_sample && (o_in != w_exp);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) w_next = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (abort)       w_next = S_IDLE;
            else if (w_last) w_next = S_FINISH;
         end
         S_FINISH: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vec       <= '0;
         r_hold      <= '0;
         r_pass_cnt  <= '0;
         r_err_count <= '0;
         r_err_valid <= 1'b0;
         r_first_err <= '0;
         r_pass      <= 1'b0;
      end else if (w_accept) begin
         r_vec       <= '0;
         r_hold      <= '0;
         r_pass_cnt  <= '0;
         r_err_count <= '0;
         r_err_valid <= 1'b0;
         r_first_err <= '0;
         r_pass      <= 1'b0;
      end else if (r_state == S_RUN) begin
         if (abort) begin
            // drop the drive back to 0; error fields keep partial values
            r_vec  <= '0;
            r_hold <= '0;
         end else if (r_hold == HOLD_MAX) begin
            r_hold <= '0;
            // wraps 15->0, so the drive is back at 0 when the run ends
            r_vec  <= r_vec + 4'd1;
            if (r_vec == 4'hF) r_pass_cnt <= r_pass_cnt + 1'b1;
            if (w_mismatch) begin
               if (r_err_count != ERR_MAX) r_err_count <= r_err_count + 1'b1;
               if (!r_err_valid) begin
                  r_first_err <= r_vec;
                  r_err_valid <= 1'b1;
               end
            end
            // err_valid tracks "any mismatch", unaffected by saturation;
            // include the final sample's own result
            if (w_last) r_pass <= !(r_err_valid || w_mismatch);
         end else begin
            r_hold <= r_hold + 1'b1;
         end
      end
   end

   assign a_out         = r_vec[3:2];
   assign b_out         = r_vec[1:0];
   assign pass          = r_pass;
   assign err_count     = r_err_count;
   assign err_valid     = r_err_valid;
   assign first_err_vec = r_first_err;

endmodule

// File: tb/tb_aoi_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_aoi_sweep_checker
// Three checker instances: A (SETTLE=1, PASSES=1) with a selectable gate
// model, B (SETTLE=1, PASSES=4) for saturation, and C (SETTLE=0) fed by a
// gate whose output lags its inputs by one cycle.
// ---------------------------------------------------------------------------
module tb_aoi_sweep_checker;

   logic clk = 1'b0;
   logic rst_n;
   logic abort;
   logic start_v [3];
   logic busy_v  [3];
   logic done_v  [3];
   logic pass_v  [3];
   logic valid_v [3];
   logic [4:0] err_v   [3];
   logic [3:0] first_v [3];
   logic [1:0] a_v [3];
   logic [1:0] b_v [3];
   logic o_a, o_b, o_c;
   logic r_dly_a, r_dly_c;

   int        mode_a, mode_b;
   logic [15:0] mask_a, mask_b;
   logic      dly_a;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   function automatic logic aoi(input logic [3:0] v);
      return ~((v[3] & v[2]) | (v[1] & v[0]));
   endfunction

   // mode 0 golden, 1 stuck-at-0, 2 stuck-at-1, 3 golden with mask-selected faults
   function automatic logic gate(input int mode, input logic [15:0] mask, input logic [3:0] v);
      case (mode)
         1:       return 1'b0;
         2:       return 1'b1;
         3:       return aoi(v) ^ mask[v];
         default: return aoi(v);
      endcase
   endfunction

   always_ff @(posedge clk) r_dly_a <= aoi({a_v[0], b_v[0]});
   always_ff @(posedge clk) r_dly_c <= aoi({a_v[2], b_v[2]});

   always_comb o_a = dly_a ? r_dly_a : gate(mode_a, mask_a, {a_v[0], b_v[0]});
   always_comb o_b = gate(mode_b, mask_b, {a_v[1], b_v[1]});
   always_comb o_c = r_dly_c;

   aoi_sweep_checker #(.SETTLE(1), .PASSES(1), .ERR_W(5)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort),
      .a_out(a_v[0]), .b_out(b_v[0]), .o_in(o_a),
      .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
      .err_count(err_v[0]), .err_valid(valid_v[0]), .first_err_vec(first_v[0]));

   aoi_sweep_checker #(.SETTLE(1), .PASSES(4), .ERR_W(5)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(1'b0),
      .a_out(a_v[1]), .b_out(b_v[1]), .o_in(o_b),
      .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
      .err_count(err_v[1]), .err_valid(valid_v[1]), .first_err_vec(first_v[1]));

   aoi_sweep_checker #(.SETTLE(0), .PASSES(1), .ERR_W(5)) u_c (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(1'b0),
      .a_out(a_v[2]), .b_out(b_v[2]), .o_in(o_c),
      .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
      .err_count(err_v[2]), .err_valid(valid_v[2]), .first_err_vec(first_v[2]));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: walk the samples a run would take and score each one.
   task automatic model(input int mode, input logic [15:0] mask, input int nsamp,
                        output int err, output int first, output int valid);
      err = 0; first = 0; valid = 0;
      for (int s = 0; s < nsamp; s++) begin
         logic [3:0] v;
         v = 4'(s % 16);
         if (gate(mode, mask, v) != aoi(v)) begin
            if (valid == 0) begin first = int'(v); valid = 1; end
            if (err < 31) err++;
         end
      end
   endtask

   // Start instance i, wait for done (bounded); returns edges from acceptance to done.
   task automatic run_inst(input int i, input bit mid_start, input bit with_abort,
                           output int cycles);
      int step_bad;
      step_bad = 0;
      repeat (2) @(negedge clk);
      start_v[i] = 1'b1;
      if (with_abort) abort = 1'b1;
      @(posedge clk); #1;
      chk("busy_after_start", int'(busy_v[i]), 1);
      start_v[i] = 1'b0;
      abort = 1'b0;
      cycles = 0;
      while (!done_v[i] && cycles < 1000) begin
         @(posedge clk); #1;
         cycles++;
         if (mid_start && cycles == 10) start_v[i] = 1'b1;
         if (mid_start && cycles == 11) start_v[i] = 1'b0;
         if (i == 0 && int'({a_v[0], b_v[0]}) != (cycles / 2) % 16) step_bad++;
      end
      chk("busy_low_at_done", int'(busy_v[i]), 0);
      if (i == 0) chk("vector_stepping_bad_cycles", step_bad, 0);
   endtask

   task automatic chk_res(input string tag, input int i, input int err, input int first,
                          input int valid, input int pss);
      chk({tag, "_err_count"}, int'(err_v[i]), err);
      chk({tag, "_first_err_vec"}, int'(first_v[i]), first);
      chk({tag, "_err_valid"}, int'(valid_v[i]), valid);
      chk({tag, "_pass"}, int'(pass_v[i]), pss);
   endtask

   typedef struct {
      int          mode;
      logic [15:0] mask;
      int          err;
      int          first;
      int          valid;
      int          pss;
   } vec_t;

   vec_t tbl [5];

   initial begin
      int cyc, e, f, v, cnt;
      tbl[0] = '{0, 16'h0000, 0, 0,  0, 1};
      tbl[1] = '{1, 16'h0000, 9, 0,  1, 0};
      tbl[2] = '{2, 16'h0000, 7, 3,  1, 0};
      tbl[3] = '{3, 16'h0100, 1, 8,  1, 0};
      tbl[4] = '{3, 16'h8000, 1, 15, 1, 0};

      rst_n = 1'b0; abort = 1'b0; dly_a = 1'b0;
      mode_a = 0; mode_b = 0; mask_a = '0; mask_b = '0;
      for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
      repeat (3) @(posedge clk); #1;
      chk("reset_outputs_A", int'({a_v[0], b_v[0], busy_v[0], done_v[0], pass_v[0],
                                   err_v[0], valid_v[0], first_v[0]}), 0);
      chk("reset_busy_BC", int'({busy_v[1], busy_v[2]}), 0);
      @(negedge clk) rst_n = 1'b1;

      // table-driven runs on instance A
      for (int t = 0; t < 5; t++) begin
         mode_a = tbl[t].mode; mask_a = tbl[t].mask;
         run_inst(0, t == 0, t == 1, cyc);
         chk($sformatf("tbl%0d_done_latency", t), cyc, 32);
         chk_res($sformatf("tbl%0d", t), 0, tbl[t].err, tbl[t].first, tbl[t].valid, tbl[t].pss);
      end

      // randomized gate faults on A, checked against the sample model
      for (int r = 0; r < 6; r++) begin
         mode_a = int'($urandom_range(0, 3)); mask_a = 16'($urandom);
         model(mode_a, mask_a, 16, e, f, v);
         run_inst(0, 1'b0, 1'b0, cyc);
         chk($sformatf("rnd%0d_done_latency", r), cyc, 32);
         chk_res($sformatf("rnd%0d", r), 0, e, f, v, (v == 0) ? 1 : 0);
      end

      // instance B: four passes, saturating counter
      mode_b = 1;
      run_inst(1, 1'b0, 1'b0, cyc);
      chk("sat_done_latency", cyc, 128);
      chk_res("sat", 1, 31, 0, 1, 0);
      for (int r = 0; r < 2; r++) begin
         mode_b = 3; mask_b = 16'($urandom);
         model(mode_b, mask_b, 64, e, f, v);
         run_inst(1, 1'b0, 1'b0, cyc);
         chk($sformatf("b_rnd%0d_done_latency", r), cyc, 128);
         chk_res($sformatf("b_rnd%0d", r), 1, e, f, v, (v == 0) ? 1 : 0);
      end

      // instance C: SETTLE=0 sees the previous vector's gate output
      e = 0; f = 0; v = 0;
      for (int k = 0; k < 16; k++) begin
         if (aoi(4'(k)) != aoi(4'((k == 0) ? 0 : k - 1))) begin
            if (v == 0) begin f = k; v = 1; end
            e++;
         end
      end
      run_inst(2, 1'b0, 1'b0, cyc);
      chk("settle0_done_latency", cyc, 16);
      chk_res("settle0_delay", 2, e, f, v, 0);
      // same lagging gate on A (SETTLE=1) settles in time
      dly_a = 1'b1;
      run_inst(0, 1'b0, 1'b0, cyc);
      chk_res("settle1_delay", 0, 0, 0, 0, 1);
      dly_a = 1'b0;

      // abort during vector 5 with stuck-at-0 gate
      mode_a = 1;
      repeat (2) @(negedge clk);
      start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      cnt = 0;
      while ({a_v[0], b_v[0]} != 4'd5 && cnt < 100) begin
         @(posedge clk); #1; cnt++;
      end
      chk("abort_reached_vec5", int'({a_v[0], b_v[0]}), 5);
      @(negedge clk) abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      model(1, 16'h0000, 5, e, f, v);
      chk("abort_busy", int'(busy_v[0]), 0);
      chk("abort_ab_zero", int'({a_v[0], b_v[0]}), 0);
      chk_res("abort", 0, e, f, v, 0);
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done_v[0] || busy_v[0]) cnt++;
      end
      chk("abort_no_done_or_busy", cnt, 0);

      // asynchronous reset between edges mid-run
      mode_a = 1;
      repeat (2) @(negedge clk);
      start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", int'({a_v[0], b_v[0], busy_v[0], done_v[0], pass_v[0],
                                       err_v[0], valid_v[0], first_v[0]}), 0);
      @(negedge clk) rst_n = 1'b1;
      mode_a = 0;
      run_inst(0, 1'b0, 1'b0, cyc);
      chk("post_reset_done_latency", cyc, 32);
      chk_res("post_reset", 0, 0, 0, 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
